// File: rtl/ahb_slave_access_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_slave_access_arbiter
//   Two-port round-robin AHB-Lite master sequencer. Each accepted command
//   from a requester becomes one single NONSEQ transfer to a shared slave;
//   completion (ACK), error status (ERR) and read data (RDATA) are returned
//   to the requester that issued the command. Misaligned or oversized
//   commands are rejected without touching the bus.
//
// Ports
//   HCLK, HRESETN     clock, asynchronous active-low reset
//   REQ/WR[1:0]       per-requester request and write flag
//   ADDR, WDATA, SIZE packed per-requester command fields
//   ACK/ERR[1:0]      one-cycle completion pulse and error flag
//   RDATA             read data, valid with ACK
//   GNT, BUSY         current/last owner, FSM-not-idle
//   HSEL..HWDATA      AHB-Lite master outputs
//   HRDATA, HREADY,
//   HRESP             AHB-Lite slave response
// ---------------------------------------------------------------------------
module ahb_slave_access_arbiter #(
    parameter int unsigned AWIDTH    = 10,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic [1:0]            REQ,
    input  logic [1:0]            WR,
    input  logic [2*AWIDTH-1:0]   ADDR,
    input  logic [63:0]           WDATA,
    input  logic [5:0]            SIZE,
    output logic [1:0]            ACK,
    output logic [1:0]            ERR,
    output logic [31:0]           RDATA,
    output logic                  GNT,
    output logic                  BUSY,
    output logic                  HSEL,
    output logic [AWIDTH-1:0]     HADDR,
    output logic                  HWRITE,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic                  HMASTLOCK,
    output logic [3:0]            HPROT,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_REJ} state_e;

    state_e              state_q,  state_d;
    logic                last_q,   last_d;
    logic                gnt_q,    gnt_d;
    logic [31:0]         wdata_q,  wdata_d;
    logic [1:0]          ack_q,    ack_d;
    logic [1:0]          err_q,    err_d;
    logic [31:0]         rdata_q,  rdata_d;
    logic                busy_q,   busy_d;
    logic                hsel_q,   hsel_d;
    logic [AWIDTH-1:0]   haddr_q,  haddr_d;
    logic                hwrite_q, hwrite_d;
    logic [1:0]          htrans_q, htrans_d;
    logic [2:0]          hsize_q,  hsize_d;
    logic [31:0]         hwdata_q, hwdata_d;

    logic [1:0]          elig;
    logic                sel;
    logic                sel_wr;
    logic [AWIDTH-1:0]   sel_addr;
    logic [31:0]         sel_wdata;
    logic [2:0]          sel_size;
    logic                cmd_ok;

    // Requester selection and command validation
    always_comb begin
        // A requester whose ACK is currently high still holds REQ for the
        // command just completed; masking it prevents a duplicate issue.
        elig = REQ & ~ack_q;
        case (elig)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            default: sel = ~last_q;
        endcase

        sel_wr    = sel ? WR[1]                     : WR[0];
        sel_addr  = sel ? ADDR[2*AWIDTH-1:AWIDTH]   : ADDR[AWIDTH-1:0];
        sel_wdata = sel ? WDATA[63:32]              : WDATA[31:0];
        sel_size  = sel ? SIZE[5:3]                 : SIZE[2:0];

        case (sel_size)
            3'd0:    cmd_ok = 1'b1;
            3'd1:    cmd_ok = ~sel_addr[0];
            3'd2:    cmd_ok = (sel_addr[1:0] == 2'b00);
            default: cmd_ok = 1'b0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        wdata_d  = wdata_q;
        ack_d    = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        hsel_d   = hsel_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        htrans_d = htrans_q;
        hsize_d  = hsize_q;
        hwdata_d = hwdata_q;

        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    last_d  = sel;
                    gnt_d   = sel;
                    wdata_d = sel_wdata;
                    if (cmd_ok) begin
                        state_d  = S_ADDR;
                        hsel_d   = 1'b1;
                        htrans_d = 2'b10;
                        haddr_d  = sel_addr;
                        hwrite_d = sel_wr;
                        hsize_d  = sel_size;
                    end else begin
                        state_d  = S_REJ;
                    end
                end
            end
            S_ADDR: begin
                state_d  = S_DATA;
                hsel_d   = 1'b0;
                htrans_d = 2'b00;
                if (hwrite_q) begin
                    hwdata_d = wdata_q;
                end
            end
            S_DATA: begin
                // First cycle of a two-cycle ERROR response has HREADY low,
                // so it is absorbed here as an ordinary wait state.
                if (HREADY) begin
                    state_d       = S_IDLE;
                    ack_d[gnt_q]  = 1'b1;
                    err_d[gnt_q]  = HRESP;
                    if (!hwrite_q) begin
                        rdata_d = HRDATA;
                    end
                end
            end
            S_REJ: begin
                state_d      = S_IDLE;
                ack_d[gnt_q] = 1'b1;
                err_d[gnt_q] = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            wdata_q  <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            hsel_q   <= 1'b0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            htrans_q <= 2'b00;
            hsize_q  <= '0;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            hsel_q   <= hsel_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            htrans_q <= htrans_d;
            hsize_q  <= hsize_d;
            hwdata_q <= hwdata_d;
        end
    end

    assign ACK       = ack_q;
    assign ERR       = err_q;
    assign RDATA     = rdata_q;
    assign GNT       = gnt_q;
    assign BUSY      = busy_q;
    assign HSEL      = hsel_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HTRANS    = htrans_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VAL;

endmodule

// File: tb/tb_ahb_slave_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_access_arbiter
//   Directed bench for ahb_slave_access_arbiter with a small AHB slave model
//   (word memory, configurable wait states and two-cycle ERROR response).
// ---------------------------------------------------------------------------
module tb_ahb_slave_access_arbiter;

    localparam int unsigned AW = 10;

    logic            HCLK = 1'b0;
    logic            HRESETN;
    logic [1:0]      REQ, WR;
    logic [2*AW-1:0] ADDR;
    logic [63:0]     WDATA;
    logic [5:0]      SIZE;
    logic [1:0]      ACK, ERR;
    logic [31:0]     RDATA;
    logic            GNT, BUSY, HSEL;
    logic [AW-1:0]   HADDR;
    logic            HWRITE;
    logic [1:0]      HTRANS;
    logic [2:0]      HSIZE, HBURST;
    logic            HMASTLOCK;
    logic [3:0]      HPROT;
    logic [31:0]     HWDATA, HRDATA;
    logic            HREADY, HRESP;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 HCLK = ~HCLK;

    ahb_slave_access_arbiter #(
        .AWIDTH    (AW),
        .HPROT_VAL (4'b0011)
    ) dut (
        .HCLK      (HCLK),
        .HRESETN   (HRESETN),
        .REQ       (REQ),
        .WR        (WR),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .SIZE      (SIZE),
        .ACK       (ACK),
        .ERR       (ERR),
        .RDATA     (RDATA),
        .GNT       (GNT),
        .BUSY      (BUSY),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HMASTLOCK (HMASTLOCK),
        .HPROT     (HPROT),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    // ---------------- slave model ----------------
    logic [31:0]   mem [0:255];
    logic          dp_act, dp_wr;
    logic [AW-1:0] dp_addr;
    int unsigned   wcnt;
    int unsigned   ws_cfg;
    logic          err_cfg;

    always @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            dp_act  <= 1'b0;
            dp_wr   <= 1'b0;
            dp_addr <= '0;
            wcnt    <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (HREADY) begin
            if (dp_act && dp_wr && !err_cfg) mem[dp_addr[9:2]] <= HWDATA;
            dp_act  <= HSEL && (HTRANS == 2'b10);
            dp_addr <= HADDR;
            dp_wr   <= HWRITE;
            wcnt    <= 0;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'hDEAD_BEEF;
        if (dp_act) begin
            if (err_cfg) begin
                HREADY = (wcnt >= ws_cfg + 1);
                HRESP  = (wcnt >= ws_cfg);
            end else begin
                HREADY = (wcnt >= ws_cfg);
            end
            if (!dp_wr) HRDATA = mem[dp_addr[9:2]];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, ".ack"},    ACK,       2'b00);
        chk({tag, ".err"},    ERR,       2'b00);
        chk({tag, ".rdata"},  RDATA,     32'h0);
        chk({tag, ".gnt"},    GNT,       1'b0);
        chk({tag, ".busy"},   BUSY,      1'b0);
        chk({tag, ".hsel"},   HSEL,      1'b0);
        chk({tag, ".htrans"}, HTRANS,    2'b00);
        chk({tag, ".haddr"},  HADDR,     10'h0);
        chk({tag, ".hwrite"}, HWRITE,    1'b0);
        chk({tag, ".hsize"},  HSIZE,     3'd0);
        chk({tag, ".hwdata"}, HWDATA,    32'h0);
        chk({tag, ".hburst"}, HBURST,    3'b000);
        chk({tag, ".hlock"},  HMASTLOCK, 1'b0);
        chk({tag, ".hprot"},  HPROT,     4'b0011);
    endtask

    typedef struct {
        int unsigned   r;
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [2:0]    size;
        int unsigned   ws;
        logic          err_rsp;
        logic          rej;
        int unsigned   lat;
        logic          exp_err;
        logic [31:0]   exp_rdata;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int unsigned got;
        logic [1:0]  exp_e;
        string       p;
        got = 0;
        p = $sformatf("v%0d", idx);
        ws_cfg  = v.ws;
        err_cfg = v.err_rsp;
        ADDR  = '1;
        WDATA = {2{32'h5A5A_5A5A}};
        SIZE  = '1;
        WR    = ~{2{v.wr}};
        ADDR[v.r*AW +: AW]  = v.addr;
        WDATA[v.r*32 +: 32] = v.wdata;
        SIZE[v.r*3 +: 3]    = v.size;
        WR[v.r]             = v.wr;
        REQ      = '0;
        REQ[v.r] = 1'b1;
        for (int unsigned n = 1; n <= 20 && got == 0; n++) begin
            @(negedge HCLK);
            chk({p, ".ack_other"}, ACK[1-v.r], 1'b0);
            if (ACK[v.r]) begin
                got = n;
            end else if (n == 1) begin
                chk({p, ".busy"},   BUSY,   1'b1);
                chk({p, ".gnt1"},   GNT,    v.r);
                chk({p, ".hsel1"},  HSEL,   !v.rej);
                chk({p, ".htrans1"}, HTRANS, v.rej ? 2'b00 : 2'b10);
                if (!v.rej) begin
                    chk({p, ".haddr1"},  HADDR,  v.addr);
                    chk({p, ".hsize1"},  HSIZE,  v.size);
                    chk({p, ".hwrite1"}, HWRITE, v.wr);
                end
            end else if (!v.rej) begin
                chk({p, ".htrans_d"}, HTRANS, 2'b00);
                chk({p, ".hsel_d"},   HSEL,   1'b0);
                chk({p, ".haddr_d"},  HADDR,  v.addr);
                chk({p, ".hsize_d"},  HSIZE,  v.size);
                if (v.wr) chk({p, ".hwdata_d"}, HWDATA, v.wdata);
            end
        end
        exp_e = '0;
        exp_e[v.r] = v.exp_err;
        chk({p, ".latency"}, got,   v.lat);
        chk({p, ".err"},     ERR,   exp_e);
        chk({p, ".rdata"},   RDATA, v.exp_rdata);
        chk({p, ".gnt"},     GNT,   v.r);
        REQ = '0;
        @(negedge HCLK);
        chk({p, ".ack_pulse"}, ACK,  2'b00);
        chk({p, ".err_pulse"}, ERR,  2'b00);
        chk({p, ".idle"},      BUSY, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t       tbl [13];
        logic [1:0] exp_ack;

        HRESETN = 1'b0;
        REQ = '0; WR = '0; ADDR = '0; WDATA = '0; SIZE = '0;
        ws_cfg = 0; err_cfg = 1'b0;

        //            r  wr    addr    wdata         sz  ws err  rej lat e     rdata
        tbl[0]  = '{0, 1'b1, 10'h010, 32'hA5A5_0001, 3'd2, 0, 1'b0, 1'b0, 3, 1'b0, 32'h0000_0000};
        tbl[1]  = '{0, 1'b0, 10'h010, 32'h0,         3'd2, 0, 1'b0, 1'b0, 3, 1'b0, 32'hA5A5_0001};
        tbl[2]  = '{1, 1'b1, 10'h020, 32'h1234_5678, 3'd2, 2, 1'b0, 1'b0, 5, 1'b0, 32'hA5A5_0001};
        tbl[3]  = '{1, 1'b0, 10'h020, 32'h0,         3'd2, 2, 1'b0, 1'b0, 5, 1'b0, 32'h1234_5678};
        tbl[4]  = '{0, 1'b1, 10'h030, 32'hCAFE_F00D, 3'd2, 0, 1'b1, 1'b0, 4, 1'b1, 32'h1234_5678};
        tbl[5]  = '{1, 1'b0, 10'h030, 32'h0,         3'd2, 0, 1'b0, 1'b0, 3, 1'b0, 32'h0000_0000};
        tbl[6]  = '{0, 1'b0, 10'h010, 32'h0,         3'd2, 0, 1'b0, 1'b0, 3, 1'b0, 32'hA5A5_0001};
        tbl[7]  = '{0, 1'b1, 10'h012, 32'hDEAD_DEAD, 3'd2, 0, 1'b0, 1'b1, 2, 1'b1, 32'hA5A5_0001};
        tbl[8]  = '{1, 1'b0, 10'h000, 32'h0,         3'd3, 0, 1'b0, 1'b1, 2, 1'b1, 32'hA5A5_0001};
        tbl[9]  = '{1, 1'b1, 10'h042, 32'h0000_BEEF, 3'd1, 0, 1'b0, 1'b0, 3, 1'b0, 32'hA5A5_0001};
        tbl[10] = '{0, 1'b1, 10'h043, 32'hFFFF_FFFF, 3'd1, 0, 1'b0, 1'b1, 2, 1'b1, 32'hA5A5_0001};
        tbl[11] = '{0, 1'b0, 10'h041, 32'h0,         3'd0, 0, 1'b0, 1'b0, 3, 1'b0, 32'h0000_BEEF};
        tbl[12] = '{1, 1'b0, 10'h040, 32'h0,         3'd2, 1, 1'b0, 1'b0, 4, 1'b0, 32'h0000_BEEF};

        repeat (3) @(negedge HCLK);
        check_reset_outs("por");
        HRESETN = 1'b1;
        @(negedge HCLK);

        // Round robin: both requesters held from reset, requester 0 first.
        WR    = 2'b11;
        ADDR  = {10'h104, 10'h100};
        WDATA = {32'h1111_1111, 32'h2222_2222};
        SIZE  = {3'd2, 3'd2};
        REQ   = 2'b11;
        for (int n = 1; n <= 12; n++) begin
            @(negedge HCLK);
            exp_ack = (n % 6 == 3) ? 2'b01 : (n % 6 == 0) ? 2'b10 : 2'b00;
            chk($sformatf("rr.ack@%0d", n), ACK, exp_ack);
            if (n % 3 == 1) chk($sformatf("rr.gnt@%0d", n), GNT, ((n - 1) / 3) % 2);
        end
        REQ = '0;
        @(negedge HCLK);
        chk("rr.idle", BUSY, 1'b0);

        for (int i = 0; i < 13; i++) run_vec(i, tbl[i]);

        // Reset while a data phase is stalled by wait states.
        ws_cfg = 6; err_cfg = 1'b0;
        ADDR = '0; ADDR[2*AW-1:AW] = 10'h020;
        WR = 2'b00; SIZE = {3'd2, 3'd2};
        REQ = 2'b10;
        repeat (3) @(negedge HCLK);
        chk("rst.pre_busy",  BUSY,  1'b1);
        chk("rst.pre_haddr", HADDR, 10'h020);
        #1;
        HRESETN = 1'b0;
        REQ = '0;
        #1;
        check_reset_outs("rst");
        repeat (2) @(negedge HCLK);
        chk("rst.no_ack", ACK, 2'b00);
        HRESETN = 1'b1;
        ws_cfg = 0;
        ADDR = {10'h020, 10'h010};
        REQ  = 2'b11;
        @(negedge HCLK);
        chk("rst.gnt_first", GNT,   1'b0);
        chk("rst.haddr",     HADDR, 10'h010);
        @(negedge HCLK);
        chk("rst.ack_mid", ACK, 2'b00);
        @(negedge HCLK);
        chk("rst.ack0", ACK, 2'b01);
        chk("rst.err0", ERR, 2'b00);
        REQ = '0;
        @(negedge HCLK);
        chk("rst.idle", BUSY, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule

// File: doc/ahb_slave_access_arbiter.md
Name: ahb_slave_access_arbiter

Overview:
- Two-requester, round-robin AHB-Lite master sequencer that shares one AHB slave (memory-model slave or real peripheral) between two simple command ports.
- Each accepted command becomes one single, non-burst AHB transfer: a NONSEQ address phase followed by a data phase.
- The block returns read data and error status to the requester that issued the command.
- It sits between testbench or fabric command sources and the slave's AHB port.

Parameters:
- AWIDTH, 10, width of the AHB address and of each requester address.
- HPROT_VAL, 4'b0011, constant driven on HPROT.

Ports:
- HCLK  in  1  clock.
- HRESETN  in  1  asynchronous active-low reset.
- REQ  in  2  per-requester request; held high with a stable command until the matching ACK.
- WR  in  2  per-requester write (1) or read (0).
- ADDR  in  2*AWIDTH  requester i uses ADDR[i*AWIDTH +: AWIDTH].
- WDATA  in  64  requester i uses WDATA[i*32 +: 32].
- SIZE  in  6  requester i uses SIZE[i*3 +: 3], AHB HSIZE encoding.
- ACK  out  2  one-cycle completion pulse for requester i.
- ERR  out  2  valid with ACK; 1 = slave ERROR response or rejected command.
- RDATA  out  32  read data, valid with ACK (shared by both requesters).
- GNT  out  1  index of the requester owning the current or last transfer.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- HSEL  out  1  slave select.
- HADDR  out  AWIDTH  AHB address.
- HWRITE  out  1  AHB write.
- HTRANS  out  2  AHB transfer type.
- HSIZE  out  3  AHB size.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HMASTLOCK  out  1  constant 0.
- HPROT  out  4  constant HPROT_VAL.
- HWDATA  out  32  AHB write data.
- HRDATA  in  32  slave read data.
- HREADY  in  1  slave HREADYOUT; the slave's HREADYIN is tied to this same net at the top level.
- HRESP  in  1  slave response; 1 = ERROR.

Behaviour:

Reset values (all outputs registered):
- ACK = 0, ERR = 0, RDATA = 0, GNT = 0, BUSY = 0.
- HSEL = 0, HTRANS = 2'b00, HADDR = 0, HWRITE = 0, HSIZE = 0, HWDATA = 0.
- FSM = IDLE, LAST = 1.

FSM states: IDLE, ADDR, DATA, REJ.

IDLE:
- A requester is eligible when REQ[i] = 1 and ACK[i] = 0. Masking by ACK prevents re-issuing a command whose REQ has not yet dropped.
- Neither eligible: stay in IDLE.
- One eligible: grant it.
- Both eligible: grant ~LAST.
- On grant:
  - Set LAST = GNT = i.
  - Latch WR, ADDR, WDATA and SIZE of requester i.
  - Command invalid (SIZE > 2, or ADDR not aligned to 2^SIZE bytes): go to REJ.
  - Otherwise go to ADDR.

ADDR (exactly 1 cycle):
- Drive HSEL = 1, HTRANS = 2'b10 (NONSEQ), and HADDR/HWRITE/HSIZE from the latch.
- Next state: DATA.
- The bus is always idle on entry, so HREADY = 1 is guaranteed at the end of this phase.

DATA:
- Drive HTRANS = 2'b00 and HSEL = 0.
- HWDATA = latched WDATA on writes; it holds its last value on reads.
- Wait states: while HREADY = 0, stay in DATA with all outputs held.
- HRESP = 1 with HREADY = 0 (first cycle of an ERROR response): stay in DATA.
- On HREADY = 1, register into the following cycle:
  - ACK[GNT] = 1.
  - ERR[GNT] = HRESP.
  - RDATA = HRDATA on reads; RDATA unchanged on writes.
  - Next state: IDLE.

REJ (1 cycle, no bus activity):
- Register ACK[GNT] = 1 and ERR[GNT] = 1 into the following cycle.
- Next state: IDLE.

Latency:
- Request in IDLE to ACK = 3 cycles with zero wait states; each slave wait state adds 1 cycle.
- Rejected commands: ACK 2 cycles after the request.
- Back-to-back sustained throughput: 1 transfer per 3 cycles.

ACK/ERR:
- ACK and ERR assert for exactly one cycle.
- At most one ACK bit is high in any cycle.

REQ dropped mid-transfer: the transfer completes and ACK is still issued.

Reset mid-operation: asynchronous return to the reset values; any in-flight transfer is abandoned and no ACK is issued for it.

Test Plan:
1. Single write, then read, zero wait states:
   - REQ0 writes 0xA5A5_0001 to 0x010 (SIZE=2), then reads 0x010.
   - Write ACK0 at cycle +3 with ERR0 = 0.
   - Read returns RDATA = 0xA5A5_0001.
   - HTRANS sequence is 10 then 00 for each transfer.
2. Round-robin fairness:
   - REQ[1:0] = 2'b11 held continuously after reset.
   - Grants alternate 0,1,0,1; four ACKs arrive in 12 cycles.
   - No requester is re-issued while its ACK bit is high.
3. Slave wait states:
   - Slave inserts 2 wait states on a read of 0x020.
   - ACK arrives at cycle +5.
   - HADDR, HSIZE and HWDATA remain stable through the wait states.
4. Slave ERROR:
   - Two-cycle HRESP = 1 response on a write.
   - ACK with ERR = 1 for the correct requester.
   - FSM returns to IDLE.
   - The next request proceeds normally.
5. Rejected commands:
   - SIZE = 2 with ADDR = 0x012, and separately SIZE = 3.
   - HSEL and HTRANS stay 0.
   - ACK with ERR = 1 at cycle +2.
6. Reset in DATA:
   - HRESETN driven low during a waited data phase.
   - All outputs reset immediately and no ACK is issued.
   - After release, REQ0 wins first (LAST = 1).
